shift_arbiter: RTL and testbench
================================

SHIFT_ARBITER -- requirements
Module: shift_arbiter

Interface
REQ-001 Parameter: FIXED_PRIO, default 0, meaning 0 = round-robin arbitration and 1 = requester 0 always wins.
REQ-002 Port: Clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 Port: Reset_n  input  1  asynchronous, active-low reset.
REQ-004 Port: Req0_valid  input  1  requester 0 presents an operation.
REQ-005 Port: Req0_op  input  2  requester 0 opcode: 00 SLL, 01 SRL, 11 SRA, 10 reserved.
REQ-006 Port: Req0_a  input  32  requester 0 operand.
REQ-007 Port: Req0_shamt  input  5  requester 0 shift amount.
REQ-008 Port: Req0_ready  output  1  requester 0 transfer accepted this cycle.
REQ-009 Port: Req1_valid / Req1_op / Req1_a / Req1_shamt / Req1_ready  same directions and widths as REQ-004..008, for requester 1.
REQ-010 Port: Resp_valid  output  1  result register holds a result.
REQ-011 Port: Resp_ready  input  1  consumer takes the result this cycle.
REQ-012 Port: Resp_y  output  32  shifted result.
REQ-013 Port: Resp_id  output  1  index of the requester that owns Resp_y.
REQ-014 Port: Resp_err  output  1  set when the result came from reserved op 10.

Function
REQ-015 The block SHALL instantiate exactly one left and one right 32-bit logical/arithmetic barrel shifter and share them between both requesters.
REQ-016 Transfer rule: ReqN is accepted in a cycle when ReqN_valid=1, ReqN is granted, and slot_free = (!Resp_valid || Resp_ready).
REQ-017 ReqN_ready SHALL be 1 only for the granted requester when slot_free=1; it is combinational from the valids, Resp_valid and Resp_ready, and is never 1 for both requesters.
REQ-018 Grant, only one requester valid: that requester wins.
REQ-019 Grant, both valid, FIXED_PRIO=0: the requester not recorded in the last_grant register wins.
REQ-020 Grant, both valid, FIXED_PRIO=1: requester 0 always wins.
REQ-021 last_grant SHALL update only on an accepted transfer; a granted-but-stalled request does not move it.
REQ-022 FSM states: EMPTY (Resp_valid=0) and FULL (Resp_valid=1).
REQ-023 EMPTY->FULL on accept.
REQ-024 FULL->FULL on simultaneous drain and accept; the new result replaces the old in the same edge, giving back-to-back throughput of 1 per cycle.
REQ-025 FULL->EMPTY on drain with no accept.
REQ-026 FULL with Resp_ready=0: Resp_y, Resp_id and Resp_err SHALL hold stable and no request is accepted.
REQ-027 Latency: a result is registered on the accepting edge and visible on the cycle after acceptance.
REQ-028 Op 00: Resp_y = A << shamt.
REQ-029 Op 01: Resp_y = A >> shamt, zero fill.
REQ-030 Op 11: Resp_y = A >> shamt, fill with A[31].
REQ-031 shamt=0: Resp_y = A for every valid op.
REQ-032 Op 10: Resp_y = 0 and Resp_err = 1; the transfer still completes normally and counts for arbitration.
REQ-033 Requester inputs are sampled only on the accepting edge; values presented while not ready are ignored.

Reset
REQ-034 Reset_n=0 SHALL asynchronously force Resp_valid=0, Resp_y=0, Resp_id=0, Resp_err=0, FSM=EMPTY and last_grant=1, so requester 0 wins the first tie.
REQ-035 A result held at reset assertion SHALL be discarded; after deassertion the first accept happens no earlier than the first rising edge with Reset_n=1.

Verification
REQ-036 Single op: Req0 SLL A=0x0000_0001, shamt=31, Resp_ready=1 -> next cycle Resp_valid=1, Resp_y=0x8000_0000, Resp_id=0, Resp_err=0.
REQ-037 Arithmetic vs logical: Req1 SRA A=0x8000_0000, shamt=4 -> Resp_y=0xF800_0000; then SRL with the same operands -> 0x0800_0000; shamt=0 -> 0x8000_0000.
REQ-038 Round-robin: both valid continuously for 4 cycles with Resp_ready=1 and FIXED_PRIO=0 -> Resp_id sequence 0,1,0,1 with one result per cycle; with FIXED_PRIO=1 -> 0,0,0,0.
REQ-039 Backpressure: FULL with Resp_ready=0 for 3 cycles while Req1 is valid -> Req1_ready=0 throughout and Resp_y stable; Resp_ready=1 -> drain and accept Req1 on the same edge.
REQ-040 Reserved op: Req0_op=10, A=0xFFFF_FFFF -> Resp_y=0, Resp_err=1; the next tie is granted to Req1.
REQ-041 Reset mid-operation: Reset_n pulled low asynchronously while FULL with Resp_ready=0 -> Resp_valid=0 immediately; after release, a tie is granted to Req0.

Source files
------------

// File: rtl/shift_arbiter.sv
// -----------------------------------------------------------------------------
// shift_arbiter
//
// Two requesters share one left and one right 32-bit barrel shifter. A single
// result register (EMPTY/FULL) holds the most recent result until the consumer
// takes it. A slot can be drained and refilled on the same edge, so the block
// can return one result per cycle.
//
// Parameters
//   FIXED_PRIO   0 = round-robin on ties, 1 = requester 0 always wins ties
//
// Ports
//   Clk, Reset_n                 clock, asynchronous active-low reset
//   ReqN_valid/op/a/shamt        requester N operation (op: 00 SLL, 01 SRL,
//                                11 SRA, 10 reserved -> result 0 with err)
//   ReqN_ready                   requester N transfer accepted this cycle
//   Resp_valid/ready             result handshake
//   Resp_y, Resp_id, Resp_err    result, owning requester, reserved-op flag
// -----------------------------------------------------------------------------
module shift_arbiter #(
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic        Req0_valid,
    input  logic [1:0]  Req0_op,
    input  logic [31:0] Req0_a,
    input  logic [4:0]  Req0_shamt,
    output logic        Req0_ready,
    input  logic        Req1_valid,
    input  logic [1:0]  Req1_op,
    input  logic [31:0] Req1_a,
    input  logic [4:0]  Req1_shamt,
    output logic        Req1_ready,
    output logic        Resp_valid,
    input  logic        Resp_ready,
    output logic [31:0] Resp_y,
    output logic        Resp_id,
    output logic        Resp_err
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t      state;
    logic        last_grant;   // requester that won the most recent accepted transfer

    logic        slot_free;
    logic        grant0;
    logic        grant1;
    logic        accept;

    logic [1:0]  sel_op;
    logic [31:0] sel_a;
    logic [4:0]  sel_shamt;

    logic [31:0] left_y;
    logic [32:0] right_ext;
    logic [31:0] right_y;
    logic [31:0] shift_y;

    // The slot accepts when empty, or when the held result leaves this cycle.
    assign slot_free = (state == EMPTY) || Resp_ready;

    // On a tie, round-robin favours the requester that did not win last time.
    assign grant1 = Req1_valid && (!Req0_valid || (!FIXED_PRIO && !last_grant));
    assign grant0 = Req0_valid && !grant1;

    assign Req0_ready = grant0 && slot_free;
    assign Req1_ready = grant1 && slot_free;
    assign accept     = Req0_ready || Req1_ready;

    assign Resp_valid = (state == FULL);

    // Operand mux in front of the single shared shifter pair.
    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        sel_op    = Req0_op;
        sel_a     = Req0_a;
        sel_shamt = Req0_shamt;
        if (grant1) begin
            sel_op    = Req1_op;
            sel_a     = Req1_a;
            sel_shamt = Req1_shamt;
        end
    end

    // Shared shifters. The right shifter works on a 33-bit value whose top bit
    // is the fill: A[31] for SRA (op[1]=1), zero for SRL.
    assign left_y    = sel_a << sel_shamt;
    assign right_ext = $signed({sel_op[1] & sel_a[31], sel_a}) >>> sel_shamt;
    assign right_y   = right_ext[31:0];

    always_comb begin
        shift_y = 32'h0;
        case (sel_op)
            2'b00:   shift_y = left_y;
            2'b01,
            2'b11:   shift_y = right_y;
            default: shift_y = 32'h0;   // reserved op returns zero
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state      <= EMPTY;
            Resp_y     <= 32'h0;
            Resp_id    <= 1'b0;
            Resp_err   <= 1'b0;
            last_grant <= 1'b1;     // requester 0 wins the first tie
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all registers update together.
            if (accept) begin
                Resp_y     <= shift_y;
                Resp_id    <= grant1;
                Resp_err   <= (sel_op == 2'b10);
                last_grant <= grant1;
            end
            case (state)
                EMPTY: if (accept) state <= FULL;
                FULL:  if (Resp_ready && !accept) state <= EMPTY;
                default: state <= EMPTY;
            endcase
        end
    end

endmodule

// File: tb/tb_shift_arbiter.sv
// -----------------------------------------------------------------------------
// tb_shift_arbiter
//
// Drives a round-robin instance and a fixed-priority instance with the same
// requester and consumer stimulus and compares each against its own
// transaction-level model (grant choice, slot occupancy, expected shift).
// -----------------------------------------------------------------------------
module tb_shift_arbiter;

    logic        Clk;
    logic        Reset_n;
    logic        req0_valid;
    logic [1:0]  req0_op;
    logic [31:0] req0_a;
    logic [4:0]  req0_shamt;
    logic        req1_valid;
    logic [1:0]  req1_op;
    logic [31:0] req1_a;
    logic [4:0]  req1_shamt;
    logic        resp_ready;

    // index 0 = round-robin instance, index 1 = fixed-priority instance
    wire [1:0]        g_r0;
    wire [1:0]        g_r1;
    wire [1:0]        g_v;
    wire [1:0]        g_id;
    wire [1:0]        g_err;
    wire [1:0][31:0]  g_y;

    int n_cmp = 0;
    int n_bad = 0;

    // model state per instance
    logic        m_full [2];
    logic        m_last [2];
    logic [31:0] m_y    [2];
    logic        m_id   [2];
    logic        m_err  [2];

    shift_arbiter #(.FIXED_PRIO(1'b0)) dut_rr (
        .Clk(Clk), .Reset_n(Reset_n),
        .Req0_valid(req0_valid), .Req0_op(req0_op), .Req0_a(req0_a),
        .Req0_shamt(req0_shamt), .Req0_ready(g_r0[0]),
        .Req1_valid(req1_valid), .Req1_op(req1_op), .Req1_a(req1_a),
        .Req1_shamt(req1_shamt), .Req1_ready(g_r1[0]),
        .Resp_valid(g_v[0]), .Resp_ready(resp_ready), .Resp_y(g_y[0]),
        .Resp_id(g_id[0]), .Resp_err(g_err[0])
    );

    shift_arbiter #(.FIXED_PRIO(1'b1)) dut_fp (
        .Clk(Clk), .Reset_n(Reset_n),
        .Req0_valid(req0_valid), .Req0_op(req0_op), .Req0_a(req0_a),
        .Req0_shamt(req0_shamt), .Req0_ready(g_r0[1]),
        .Req1_valid(req1_valid), .Req1_op(req1_op), .Req1_a(req1_a),
        .Req1_shamt(req1_shamt), .Req1_ready(g_r1[1]),
        .Resp_valid(g_v[1]), .Resp_ready(resp_ready), .Resp_y(g_y[1]),
        .Resp_id(g_id[1]), .Resp_err(g_err[1])
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // Expected result written from the operation definitions, not the datapath.
    function automatic logic [31:0] ref_shift(input logic [1:0] op, input logic [31:0] a,
                                              input logic [4:0] sh);
        logic [31:0] high_ones;
        high_ones = ~(32'hFFFF_FFFF >> sh);
        case (op)
            2'b00:   return a << sh;
            2'b01:   return a >> sh;
            2'b11:   return (a >> sh) | (a[31] ? high_ones : 32'h0);
            default: return 32'h0;
        endcase
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_full[k] = 1'b0;
            m_last[k] = 1'b1;
            m_y[k]    = 32'h0;
            m_id[k]   = 1'b0;
            m_err[k]  = 1'b0;
        end
    endtask

    // One clock cycle: check held outputs, apply new inputs, check the
    // combinational readys, then advance the models to the coming edge.
    task automatic cycle(input logic v0, input logic [1:0] op0, input logic [31:0] a0,
                         input logic [4:0] sh0, input logic v1, input logic [1:0] op1,
                         input logic [31:0] a1, input logic [4:0] sh1, input logic rr);
        logic sf, win, acc;
        @(negedge Clk);
        for (int k = 0; k < 2; k++) begin
            check($sformatf("i%0d_valid", k), 32'(g_v[k]), 32'(m_full[k]));
            if (m_full[k]) begin
                check($sformatf("i%0d_y", k), g_y[k], m_y[k]);
                check($sformatf("i%0d_id", k), 32'(g_id[k]), 32'(m_id[k]));
                check($sformatf("i%0d_err", k), 32'(g_err[k]), 32'(m_err[k]));
            end
        end
        req0_valid = v0; req0_op = op0; req0_a = a0; req0_shamt = sh0;
        req1_valid = v1; req1_op = op1; req1_a = a1; req1_shamt = sh1;
        resp_ready = rr;
        #1;
        for (int k = 0; k < 2; k++) begin
            sf  = !m_full[k] || rr;
            win = (v0 && v1) ? ((k == 1) ? 1'b0 : !m_last[k]) : v1;
            acc = sf && (v0 || v1);
            check($sformatf("i%0d_rdy0", k), 32'(g_r0[k]), 32'(acc && !win));
            check($sformatf("i%0d_rdy1", k), 32'(g_r1[k]), 32'(acc && win));
            if (acc) begin
                m_full[k] = 1'b1;
                m_id[k]   = win;
                m_last[k] = win;
                m_err[k]  = ((win ? op1 : op0) == 2'b10);
                m_y[k]    = win ? ref_shift(op1, a1, sh1) : ref_shift(op0, a0, sh0);
            end else if (rr) begin
                m_full[k] = 1'b0;
            end
        end
    endtask

    // Directed expectation on the round-robin instance right after the next edge.
    task automatic expect_rr(input string tag, input logic [31:0] y, input logic id,
                             input logic err);
        @(posedge Clk);
        #1;
        check({tag, "_v"}, 32'(g_v[0]), 32'd1);
        check({tag, "_y"}, g_y[0], y);
        check({tag, "_id"}, 32'(g_id[0]), 32'(id));
        check({tag, "_err"}, 32'(g_err[0]), 32'(err));
    endtask

    logic [31:0] held_y;

    initial begin
        Reset_n = 1'b0;
        req0_valid = 1'b0; req0_op = 2'b00; req0_a = 32'h0; req0_shamt = 5'd0;
        req1_valid = 1'b0; req1_op = 2'b00; req1_a = 32'h0; req1_shamt = 5'd0;
        resp_ready = 1'b0;
        model_reset();
        repeat (2) @(negedge Clk);
        Reset_n = 1'b1;

        // reset values
        for (int k = 0; k < 2; k++) begin
            check($sformatf("rst_i%0d_valid", k), 32'(g_v[k]), 32'd0);
            check($sformatf("rst_i%0d_y", k), g_y[k], 32'h0);
            check($sformatf("rst_i%0d_id", k), 32'(g_id[k]), 32'd0);
            check($sformatf("rst_i%0d_err", k), 32'(g_err[k]), 32'd0);
        end

        // both valid four cycles: RR alternates from requester 0, fixed stays on 0
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, 2'b00, 32'h1, 5'd1, 1'b1, 2'b01, 32'h100, 5'd4, 1'b1);
            @(posedge Clk);
            #1;
            check($sformatf("rr_seq%0d_id", i), 32'(g_id[0]), 32'(i % 2));
            check($sformatf("rr_seq%0d_v", i), 32'(g_v[0]), 32'd1);
            check($sformatf("fp_seq%0d_id", i), 32'(g_id[1]), 32'd0);
        end

        // single SLL to the top bit
        cycle(1'b1, 2'b00, 32'h0000_0001, 5'd31, 1'b0, 2'b00, 32'h0, 5'd0, 1'b1);
        expect_rr("sll31", 32'h8000_0000, 1'b0, 1'b0);

        // arithmetic vs logical right shifts, then shamt 0
        cycle(1'b0, 2'b00, 32'h0, 5'd0, 1'b1, 2'b11, 32'h8000_0000, 5'd4, 1'b1);
        expect_rr("sra4", 32'hF800_0000, 1'b1, 1'b0);
        cycle(1'b0, 2'b00, 32'h0, 5'd0, 1'b1, 2'b01, 32'h8000_0000, 5'd4, 1'b1);
        expect_rr("srl4", 32'h0800_0000, 1'b1, 1'b0);
        cycle(1'b0, 2'b00, 32'h0, 5'd0, 1'b1, 2'b11, 32'h8000_0000, 5'd0, 1'b1);
        expect_rr("sra0", 32'h8000_0000, 1'b1, 1'b0);

        // reserved op, then the next tie goes to requester 1 on the RR instance
        cycle(1'b1, 2'b10, 32'hFFFF_FFFF, 5'd7, 1'b0, 2'b00, 32'h0, 5'd0, 1'b1);
        expect_rr("rsvd", 32'h0, 1'b0, 1'b1);
        cycle(1'b1, 2'b00, 32'h3, 5'd2, 1'b1, 2'b01, 32'hF0, 5'd4, 1'b1);
        expect_rr("tie_after_rsvd", 32'h0000_000F, 1'b1, 1'b0);
        check("fp_tie_after_rsvd_id", 32'(g_id[1]), 32'd0);

        // backpressure: fill, stall three cycles with requester 1 waiting, then drain+accept
        cycle(1'b1, 2'b00, 32'h0000_00A5, 5'd8, 1'b0, 2'b00, 32'h0, 5'd0, 1'b1);
        expect_rr("bp_fill", 32'h0000_A500, 1'b0, 1'b0);
        held_y = 32'h0000_A500;
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 2'b00, 32'h0, 5'd0, 1'b1, 2'b11, 32'hC000_0000, 5'd1, 1'b0);
            check($sformatf("bp_stall%0d_rdy1", i), 32'(g_r1[0]), 32'd0);
            check($sformatf("bp_stall%0d_y", i), g_y[0], held_y);
        end
        cycle(1'b0, 2'b00, 32'h0, 5'd0, 1'b1, 2'b11, 32'hC000_0000, 5'd1, 1'b1);
        expect_rr("bp_drain", 32'hE000_0000, 1'b1, 1'b0);

        // reset while FULL and stalled
        cycle(1'b1, 2'b00, 32'h0000_0011, 5'd1, 1'b0, 2'b00, 32'h0, 5'd0, 1'b1);
        cycle(1'b0, 2'b00, 32'h0, 5'd0, 1'b1, 2'b01, 32'hFF, 5'd1, 1'b0);
        #2;
        Reset_n = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            check($sformatf("midrst_i%0d_valid", k), 32'(g_v[k]), 32'd0);
            check($sformatf("midrst_i%0d_y", k), g_y[k], 32'h0);
        end
        model_reset();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        @(posedge Clk);
        @(negedge Clk);
        check("midrst_hold_valid", 32'(g_v[0]), 32'd0);
        Reset_n = 1'b1;
        cycle(1'b1, 2'b00, 32'h5, 5'd1, 1'b1, 2'b00, 32'h7, 5'd1, 1'b1);
        expect_rr("post_rst_tie", 32'h0000_000A, 1'b0, 1'b0);

        // randomized traffic against the models
        for (int i = 0; i < 400; i++) begin
            logic [31:0] a0, a1;
            a0 = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
            a1 = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom;
            cycle(1'($urandom_range(0, 1)), 2'($urandom), a0, 5'($urandom),
                  1'($urandom_range(0, 1)), 2'($urandom), a1, 5'($urandom),
                  ($urandom_range(0, 3) != 0));
        end
        // final output check for the last accepted transfer
        cycle(1'b0, 2'b00, 32'h0, 5'd0, 1'b0, 2'b00, 32'h0, 5'd0, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
